sram_word_ctrl: RTL and testbench

//  Converts 32-bit word requests from the Murax SoC bus into two 16-bit cycles on the

---
 rtl/sram_word_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_sram_word_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_word_ctrl.sv
// sram_word_ctrl: turns 32-bit word requests into two 16-bit cycles on an async 256Kx16 SRAM.
// Every SRAM-facing output is registered from the next-state decode so the pads never glitch.
module sram_word_ctrl #(
   parameter int ADDR_WIDTH  = 18,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  io_mainClk,
   input  logic                  io_reset,
   // cmd handshake: a request transfers on a rising edge where io_cmd_valid && io_cmd_ready;
   // write/address/data/mask are sampled only on that edge and need not be held afterwards.
   input  logic                  io_cmd_valid,
   output logic                  io_cmd_ready,
   input  logic                  io_cmd_write,
   input  logic [ADDR_WIDTH-2:0] io_cmd_address,
   input  logic [31:0]           io_cmd_data,
   input  logic [3:0]            io_cmd_mask,
   output logic                  io_rsp_valid,
   output logic [31:0]           io_rsp_data,
   output logic [ADDR_WIDTH-1:0] io_sram_addr,
   input  logic [15:0]           io_sram_dat_read,
   output logic [15:0]           io_sram_dat_write,
   output logic                  io_sram_dat_writeEnable,
   output logic                  io_sram_cs,
   output logic                  io_sram_we,
   output logic                  io_sram_oe,
   output logic                  io_sram_ub,
   output logic                  io_sram_lb,
   output logic [2:0]            io_dbg_state
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_STROBE  = 3'd2,
      ST_RECOVER = 3'd3,
      ST_RSP     = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic                  half_q, half_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                  write_q;
   logic [ADDR_WIDTH-2:0] addr_q;
   logic [31:0]           data_q;
   logic [3:0]            mask_q;
   logic [15:0]           rd_lo_q, rd_hi_q;

   logic                  cs_q, we_q, oe_q, ub_q, lb_q, wen_q, rsp_valid_q;
   logic                  cs_d, we_d, oe_d, ub_d, lb_d, wen_d, rsp_valid_d;
   logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
   logic [15:0]           dat_write_q, dat_write_d;
   logic [31:0]           rsp_data_q;

   logic                  accept;
   logic                  sample_en;
   logic                  cur_write;
   logic [ADDR_WIDTH-2:0] cur_addr;
   logic [31:0]           cur_data;
   logic [3:0]            cur_mask;
   logic [15:0]           half_data;
   logic [1:0]            half_mask;

   assign accept    = io_cmd_valid && (state_q == ST_IDLE);
   assign sample_en = (state_q == ST_STROBE) && (cnt_q == CNT_LAST) && !write_q;

   // On the accept edge the command fields are not latched yet, so decode from the inputs.
   assign cur_write = accept ? io_cmd_write   : write_q;
   assign cur_addr  = accept ? io_cmd_address : addr_q;
   assign cur_data  = accept ? io_cmd_data    : data_q;
   assign cur_mask  = accept ? io_cmd_mask    : mask_q;
   assign half_data = half_d ? cur_data[31:16] : cur_data[15:0];
   assign half_mask = half_d ? cur_mask[3:2]   : cur_mask[1:0];

   always_comb begin
      state_d = state_q;
      half_d  = half_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (io_cmd_valid) begin
               // A write half with no enabled bytes is skipped without touching the SRAM.
               if (io_cmd_write && (io_cmd_mask[1:0] == 2'b00)) begin
                  if (io_cmd_mask[3:2] != 2'b00) begin
                     state_d = ST_SETUP;
                     half_d  = 1'b1;
                  end
               end else begin
                  state_d = ST_SETUP;
                  half_d  = 1'b0;
               end
            end
         end
         ST_SETUP: begin
            state_d = ST_STROBE;
            cnt_d   = '0;
         end
         ST_STROBE: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_RECOVER;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RECOVER: begin
            if (!half_q) begin
               if (write_q && (mask_q[3:2] == 2'b00)) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_SETUP;
                  half_d  = 1'b1;
               end
            end else begin
               state_d = write_q ? ST_IDLE : ST_RSP;
            end
         end
         ST_RSP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode for the state being entered; registered below.
   always_comb begin
      cs_d        = 1'b1;
      we_d        = 1'b1;
      oe_d        = 1'b1;
      ub_d        = 1'b1;
      lb_d        = 1'b1;
      wen_d       = 1'b0;
      rsp_valid_d = 1'b0;
      sram_addr_d = sram_addr_q;
      dat_write_d = dat_write_q;
      case (state_d)
         ST_SETUP: begin
            cs_d        = 1'b0;
            sram_addr_d = {cur_addr, half_d};
            if (cur_write) begin
               wen_d       = 1'b1;
               dat_write_d = half_data;
            end else begin
               oe_d = 1'b0;
            end
         end
         ST_STROBE: begin
            cs_d = 1'b0;
            if (cur_write) begin
               wen_d = 1'b1;
               we_d  = 1'b0;
               ub_d  = ~half_mask[1];
               lb_d  = ~half_mask[0];
            end else begin
               oe_d = 1'b0;
               ub_d = 1'b0;
               lb_d = 1'b0;
            end
         end
         ST_RECOVER: begin
            // Strobes released but write data stays on the pads for hold time.
            wen_d = cur_write;
         end
         ST_RSP: begin
            rsp_valid_d = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge io_mainClk) begin
      if (io_reset) begin
         state_q     <= ST_IDLE;
         half_q      <= 1'b0;
         cnt_q       <= '0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         mask_q      <= '0;
         rd_lo_q     <= '0;
         rd_hi_q     <= '0;
         cs_q        <= 1'b1;
         we_q        <= 1'b1;
         oe_q        <= 1'b1;
         ub_q        <= 1'b1;
         lb_q        <= 1'b1;
         wen_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         sram_addr_q <= '0;
         dat_write_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         half_q      <= half_d;
         cnt_q       <= cnt_d;
         cs_q        <= cs_d;
         we_q        <= we_d;
         oe_q        <= oe_d;
         ub_q        <= ub_d;
         lb_q        <= lb_d;
         wen_q       <= wen_d;
         rsp_valid_q <= rsp_valid_d;
         sram_addr_q <= sram_addr_d;
         dat_write_q <= dat_write_d;
         if (accept) begin
            write_q <= io_cmd_write;
            addr_q  <= io_cmd_address;
            data_q  <= io_cmd_data;
            mask_q  <= io_cmd_mask;
         end
         if (sample_en) begin
            if (half_q) begin
               rd_hi_q <= io_sram_dat_read;
            end else begin
               rd_lo_q <= io_sram_dat_read;
            end
         end
         if (state_d == ST_RSP) begin
            rsp_data_q <= {rd_hi_q, rd_lo_q};
         end
      end
   end

   assign io_cmd_ready            = (state_q == ST_IDLE);
   assign io_rsp_valid            = rsp_valid_q;
   assign io_rsp_data             = rsp_data_q;
   assign io_sram_addr            = sram_addr_q;
   assign io_sram_dat_write       = dat_write_q;
   assign io_sram_dat_writeEnable = wen_q;
   assign io_sram_cs              = cs_q;
   assign io_sram_we              = we_q;
   assign io_sram_oe              = oe_q;
   assign io_sram_ub              = ub_q;
   assign io_sram_lb              = lb_q;
   assign io_dbg_state            = state_q;

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Bench for sram_word_ctrl: async SRAM model on the pins, byte-level reference memory,
// vector table, randomized commands and hand-written reset / back-to-back sequences.
module tb_sram_word_ctrl;

   localparam int AW       = 18;
   localparam int W        = 2;
   localparam int HALF_CYC = W + 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        cmd_valid, cmd_ready, cmd_write;
   logic [16:0] cmd_address;
   logic [31:0] cmd_data;
   logic [3:0]  cmd_mask;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic [17:0] sram_addr;
   logic [15:0] sram_dat_read, sram_dat_write;
   logic        sram_wen, sram_cs, sram_we, sram_oe, sram_ub, sram_lb;
   logic [2:0]  dbg_state;

   sram_word_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
      .io_mainClk(clk),
      .io_reset(rst),
      .io_cmd_valid(cmd_valid),
      .io_cmd_ready(cmd_ready),
      .io_cmd_write(cmd_write),
      .io_cmd_address(cmd_address),
      .io_cmd_data(cmd_data),
      .io_cmd_mask(cmd_mask),
      .io_rsp_valid(rsp_valid),
      .io_rsp_data(rsp_data),
      .io_sram_addr(sram_addr),
      .io_sram_dat_read(sram_dat_read),
      .io_sram_dat_write(sram_dat_write),
      .io_sram_dat_writeEnable(sram_wen),
      .io_sram_cs(sram_cs),
      .io_sram_we(sram_we),
      .io_sram_oe(sram_oe),
      .io_sram_ub(sram_ub),
      .io_sram_lb(sram_lb),
      .io_dbg_state(dbg_state)
   );

   // ---------------- async SRAM pin model ----------------
   logic [15:0] sram_mem [0:(1<<AW)-1];
   initial for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0000;

   // Bytes not enabled for output read back as junk so mis-timed sampling shows up.
   assign sram_dat_read = {(!sram_cs && !sram_oe && !sram_ub) ? sram_mem[sram_addr][15:8] : 8'hEE,
                           (!sram_cs && !sram_oe && !sram_lb) ? sram_mem[sram_addr][7:0]  : 8'hEE};

   always @(posedge clk) begin
      if (!sram_cs && !sram_we && sram_wen) begin
         if (!sram_lb) sram_mem[sram_addr][7:0]  <= sram_dat_write[7:0];
         if (!sram_ub) sram_mem[sram_addr][15:8] <= sram_dat_write[15:8];
      end
   end

   // ---------------- reference model: byte-addressed memory ----------------
   logic [7:0] ref_bytes [int];

   function automatic logic [31:0] ref_read(input logic [16:0] a);
      logic [31:0] r;
      int base;
      r = '0;
      base = int'(a) * 4;
      for (int i = 0; i < 4; i++)
         if (ref_bytes.exists(base + i)) r[8*i +: 8] = ref_bytes[base + i];
      return r;
   endfunction

   task automatic ref_write(input logic [16:0] a, input logic [31:0] d, input logic [3:0] m);
      int base;
      base = int'(a) * 4;
      for (int i = 0; i < 4; i++)
         if (m[i]) ref_bytes[base + i] = d[8*i +: 8];
   endtask

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- driver: one command, monitored until ready returns ----------------
   task automatic run_cmd(input logic w, input logic [16:0] a, input logic [31:0] d,
                          input logic [3:0] m, output int ready_cyc, output int rsp_cyc,
                          output logic [31:0] rdata, output int cs_n, output int we_n,
                          output int wen_n, output int first_ha, output int last_ha,
                          output logic [1:0] ublb);
      int n;
      ready_cyc = -1; rsp_cyc = -1; rdata = '0; cs_n = 0; we_n = 0; wen_n = 0;
      first_ha = -1; last_ha = -1; ublb = 2'b11;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_data = d; cmd_mask = m;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         check("accept_timeout", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      // This negedge is cycle 0; the command transfers on the next rising edge.
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) cmd_valid = 1'b0;
         if (!sram_cs) begin
            cs_n++;
            if (first_ha < 0) first_ha = int'(sram_addr);
            last_ha = int'(sram_addr);
         end
         if (!sram_we) begin
            we_n++;
            ublb = {sram_ub, sram_lb};
         end
         if (sram_wen) wen_n++;
         if (rsp_valid) begin
            rsp_cyc = k;
            rdata   = rsp_data;
         end
         if (cmd_ready) begin
            ready_cyc = k;
            break;
         end
      end
      if (ready_cyc < 0) check("done_timeout", 0, 1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        w;
      logic [16:0] a;
      logic [31:0] d;
      logic [3:0]  m;
      int          exp_ready;
      int          exp_rsp;
      logic [31:0] exp_rdata;
      int          exp_cs;
      int          exp_we;
      int          exp_wen;
      int          exp_first;
      int          exp_last;
      logic [1:0]  exp_ublb;
   } vec_t;

   function automatic vec_t mk(input logic w, input logic [16:0] a, input logic [31:0] d,
                               input logic [3:0] m, input int er, input int ers,
                               input logic [31:0] ed, input int ecs, input int ewe,
                               input int ewen, input int ef, input int el, input logic [1:0] eu);
      vec_t v;
      v.w = w; v.a = a; v.d = d; v.m = m;
      v.exp_ready = er; v.exp_rsp = ers; v.exp_rdata = ed;
      v.exp_cs = ecs; v.exp_we = ewe; v.exp_wen = ewen;
      v.exp_first = ef; v.exp_last = el; v.exp_ublb = eu;
      return v;
   endfunction

   vec_t vecs [12];

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          rc, rs, cs_n, we_n, wen_n, fh, lh, halves, n_acc, prev;
      logic [31:0] rd, e;
      logic [1:0]  ub_lb;
      logic        w;
      logic [16:0] a;
      logic [31:0] d;
      logic [3:0]  m;
      logic [17:0] ha_q [$];

      // A write occupies 2*(W+2) busy cycles and ready returns the cycle after;
      // a read adds the RSP cycle at 2*(W+2)+1. Skipped halves cost nothing.
      vecs[0]  = mk(1, 17'h00010, 32'h0001_2345, 4'b1111, 9, -1, 0, 6, 4, 8, 'h20, 'h21, 2'b00);
      vecs[1]  = mk(0, 17'h00010, 32'h0, 4'b1111, 10, 9, 32'h0001_2345, 6, 0, 0, 'h20, 'h21, 2'b11);
      vecs[2]  = mk(1, 17'h00020, 32'hAABB_CCDD, 4'b0100, 5, -1, 0, 3, 2, 4, 'h41, 'h41, 2'b10);
      vecs[3]  = mk(0, 17'h00020, 32'h0, 4'b0000, 10, 9, 32'h00BB_0000, 6, 0, 0, 'h40, 'h41, 2'b11);
      vecs[4]  = mk(1, 17'h1FFFF, 32'hCAFE_F00D, 4'b1111, 9, -1, 0, 6, 4, 8, 'h3FFFE, 'h3FFFF, 2'b00);
      vecs[5]  = mk(0, 17'h1FFFF, 32'h0, 4'b0000, 10, 9, 32'hCAFE_F00D, 6, 0, 0, 'h3FFFE, 'h3FFFF, 2'b11);
      vecs[6]  = mk(1, 17'h00030, 32'h5566_7788, 4'b0000, 1, -1, 0, 0, 0, 0, -1, -1, 2'b11);
      vecs[7]  = mk(0, 17'h00030, 32'h0, 4'b1111, 10, 9, 32'h0000_0000, 6, 0, 0, 'h60, 'h61, 2'b11);
      vecs[8]  = mk(1, 17'h00040, 32'h1122_3344, 4'b0011, 5, -1, 0, 3, 2, 4, 'h80, 'h80, 2'b00);
      vecs[9]  = mk(0, 17'h00040, 32'h0, 4'b1111, 10, 9, 32'h0000_3344, 6, 0, 0, 'h80, 'h81, 2'b11);
      vecs[10] = mk(1, 17'h00020, 32'h9900_0000, 4'b1000, 5, -1, 0, 3, 2, 4, 'h41, 'h41, 2'b01);
      vecs[11] = mk(0, 17'h00020, 32'h0, 4'b1111, 10, 9, 32'h99BB_0000, 6, 0, 0, 'h40, 'h41, 2'b11);

      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_data = '0; cmd_mask = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_ctl", {cmd_ready, sram_cs, sram_we, sram_oe, sram_ub, sram_lb, sram_wen, rsp_valid},
            8'b1_11111_0_0);
      check("reset_addr", sram_addr, 18'h0);
      check("reset_dat_write", sram_dat_write, 16'h0);
      check("reset_rsp_data", rsp_data, 32'h0);
      check("reset_state", dbg_state, 3'd0);

      for (int i = 0; i < 12; i++) begin
         run_cmd(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].m, rc, rs, rd, cs_n, we_n, wen_n, fh, lh, ub_lb);
         check($sformatf("v%0d_ready_cyc", i), rc, vecs[i].exp_ready);
         check($sformatf("v%0d_rsp_cyc", i), rs, vecs[i].exp_rsp);
         if (!vecs[i].w) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("v%0d_cs_cycles", i), cs_n, vecs[i].exp_cs);
         check($sformatf("v%0d_we_cycles", i), we_n, vecs[i].exp_we);
         check($sformatf("v%0d_wen_cycles", i), wen_n, vecs[i].exp_wen);
         check($sformatf("v%0d_first_haddr", i), fh, vecs[i].exp_first);
         check($sformatf("v%0d_last_haddr", i), lh, vecs[i].exp_last);
         check($sformatf("v%0d_ub_lb", i), ub_lb, vecs[i].exp_ublb);
         if (vecs[i].w) ref_write(vecs[i].a, vecs[i].d, vecs[i].m);
      end

      check("mem_20", sram_mem[18'h20], 16'h2345);
      check("mem_21", sram_mem[18'h21], 16'h0001);
      check("mem_41", sram_mem[18'h41], 16'h99BB);
      check("mem_3fffe", sram_mem[18'h3FFFE], 16'hF00D);

      // Randomized commands against the byte-level reference.
      for (int i = 0; i < 40; i++) begin
         w = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 8) == 8) ? 17'h1FFFF : 17'($urandom_range(0, 7));
         d = $urandom;
         m = 4'($urandom_range(0, 15));
         halves = w ? (int'(m[1:0] != 2'b00) + int'(m[3:2] != 2'b00)) : 2;
         if (!w) exp_q.push_back(ref_read(a));
         run_cmd(w, a, d, m, rc, rs, rd, cs_n, we_n, wen_n, fh, lh, ub_lb);
         check($sformatf("r%0d_cs_cycles", i), cs_n, halves * (W + 1));
         if (w) begin
            check($sformatf("r%0d_wr_ready", i), rc, halves * HALF_CYC + 1);
            check($sformatf("r%0d_wr_we", i), we_n, halves * W);
            ref_write(a, d, m);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("r%0d_rd_ready", i), rc, 2 * HALF_CYC + 2);
            check($sformatf("r%0d_rd_rsp", i), rs, 2 * HALF_CYC + 1);
            check($sformatf("r%0d_rd_data", i), rd, e);
            check($sformatf("r%0d_rd_wen", i), wen_n, 0);
         end
      end

      // Back-to-back reads with valid held high at the top word address.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 17'h1FFFF; cmd_mask = 4'($urandom);
      n_acc = 0; prev = -1;
      for (int k = 0; k < 46; k++) begin
         if (k > 0) @(negedge clk);
         if (cmd_valid && cmd_ready) begin
            n_acc++;
            if (prev >= 0) check("b2b_accept_spacing", k - prev, 2 * HALF_CYC + 2);
            prev = k;
            exp_q.push_back(ref_read(17'h1FFFF));
         end
         if (!sram_cs && (ha_q.size() == 0 || ha_q[$] != sram_addr)) ha_q.push_back(sram_addr);
         if (rsp_valid) begin
            if (exp_q.size() == 0) check("b2b_unexpected_rsp", 1, 0);
            else check("b2b_rdata", rsp_data, exp_q.pop_front());
         end
         if (k == 31) cmd_valid = 1'b0;
      end
      check("b2b_accepts", n_acc, 4);
      check("b2b_pending", exp_q.size(), 0);
      check("b2b_haddr_count", ha_q.size(), 8);
      if (ha_q.size() >= 2) begin
         check("b2b_haddr0", ha_q[0], 18'h3FFFE);
         check("b2b_haddr1", ha_q[1], 18'h3FFFF);
      end

      // Reset during a read strobe aborts without a response.
      @(negedge clk);
      check("rst_seq_idle", cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 17'h00010;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("rst_seq_in_strobe", {sram_cs, sram_oe}, 2'b00);
      rst = 1'b1;
      @(negedge clk);
      check("rst_abort_strobes", {sram_cs, sram_we, sram_oe, sram_ub, sram_lb}, 5'b11111);
      check("rst_abort_wen", sram_wen, 1'b0);
      check("rst_abort_rsp", rsp_valid, 1'b0);
      check("rst_abort_ready", cmd_ready, 1'b1);
      check("rst_abort_rsp_data", rsp_data, 32'h0);
      rst = 1'b0;
      n_acc = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (rsp_valid) n_acc++;
      end
      check("rst_no_rsp_after", n_acc, 0);

      run_cmd(1'b0, 17'h00010, 32'h0, 4'hF, rc, rs, rd, cs_n, we_n, wen_n, fh, lh, ub_lb);
      check("post_rst_rdata", rd, ref_read(17'h00010));
      check("post_rst_rsp_cyc", rs, 2 * HALF_CYC + 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
